// File: rtl/clusterv_sram_init_pkg.sv
// Shared types and helpers for the tile-side SRAM initiator.
// Holds the canonical request layout for the default port geometry and
// a constant-evaluable log2 used to size FIFO pointers and credit counters.
package clusterv_sram_init_pkg;

  localparam int ADR_W = 8;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W / 8;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] addr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] wdata;
  } req_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clusterv_sram_rsp_fifo.sv
// Purpose: synchronous WIDTH x DEPTH FIFO with count, used on tile response paths.
// Latency: pushed data is visible on pop_dat/pop_vld the cycle after the push edge.
// Backpressure: pop only when pop_vld & pop_rdy; the producer must respect credit (overflow asserts).
module clusterv_sram_rsp_fifo
  import clusterv_sram_init_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic             full;

  assign pop     = pop_vld & pop_rdy;
  assign full    = (cnt == CW'(DEPTH));
  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign count   = cnt;

  // Storage needs no reset: entries are only observed once counted in.
  always_ff @(posedge clock) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop leaves cnt unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push_vld) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(push_vld && full && !pop));

endmodule

// File: rtl/clusterv_sram_initiator.sv
// Purpose: turns a valid/ready request stream into byte-enable SRAM cycles; reads return in order.
// Latency: request accept edge E0 -> SRAM cmd at E0, read data on rsp_valid from E2 (empty FIFO).
// Backpressure: req_ready is a registered credit (reads in flight + FIFO < RSP_DEPTH); writes posted.
// Optional counters: define CLUSTERV_SRAM_INITIATOR_STATS_EN, otherwise stat_* read as zero.
module clusterv_sram_initiator
  import clusterv_sram_init_pkg::*;
#(
  parameter int ADR_WIDTH = 8,
  parameter int DAT_WIDTH = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADR_WIDTH-1:0]   req_addr,
  input  logic [DAT_WIDTH/8-1:0] req_sel,
  input  logic [DAT_WIDTH-1:0]   req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DAT_WIDTH-1:0]   rsp_rdata,
  output logic [ADR_WIDTH-1:0]   i_addr,
  output logic                   i_write_en,
  output logic [DAT_WIDTH/8-1:0] i_byte_en,
  output logic [DAT_WIDTH-1:0]   i_write_data,
  input  logic [DAT_WIDTH-1:0]   i_read_data,
  output logic [31:0]            stat_rd,
  output logic [31:0]            stat_wr,
  output logic [31:0]            stat_stall
);

  localparam int CNT_WIDTH = clog2(RSP_DEPTH) + 1;

  logic                 req_ready_q;
  logic                 req_acc;
  logic                 rd_acc;
  logic                 s1_rd;
  logic                 s2_rd;
  logic                 rsp_pop;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic [CNT_WIDTH-1:0] out_now;
  logic [CNT_WIDTH-1:0] out_next;

  assign req_ready = req_ready_q;
  assign req_acc   = req_valid & req_ready_q;
  assign rd_acc    = req_acc & ~req_we;
  assign rsp_pop   = rsp_valid & rsp_ready;

  // S1: command register driving the SRAM; address/data hold when idle, write enable pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_addr       <= '0;
      i_write_en   <= 1'b0;
      i_byte_en    <= '0;
      i_write_data <= '0;
      s1_rd        <= 1'b0;
    end else begin
      i_write_en <= req_acc & req_we;
      s1_rd      <= rd_acc;
      if (req_acc) begin
        i_addr       <= req_addr;
        i_byte_en    <= req_we ? req_sel : '1;
        i_write_data <= req_wdata;
      end
    end
  end

  // S2: marks the cycle in which the SRAM returns data for the read sampled from S1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s2_rd <= 1'b0;
    else        s2_rd <= s1_rd;
  end

  // Every read in S1, S2 or the FIFO holds one credit; accept and pop in one cycle cancel.
  assign out_now  = fifo_count + CNT_WIDTH'(s1_rd) + CNT_WIDTH'(s2_rd);
  assign out_next = out_now + CNT_WIDTH'(rd_acc) - CNT_WIDTH'(rsp_pop);

  // Registered credit check keeps req_ready free of combinational paths from the handshakes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) req_ready_q <= 1'b0;
    else        req_ready_q <= (out_next < CNT_WIDTH'(RSP_DEPTH));
  end

  clusterv_sram_rsp_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (s2_rd),
    .push_dat (i_read_data),
    .pop_rdy  (rsp_ready),
    .pop_vld  (rsp_valid),
    .pop_dat  (rsp_rdata),
    .count    (fifo_count)
  );

`ifdef CLUSTERV_SRAM_INITIATOR_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] stall_cnt;

  // Wrapping event counters: accepted reads, accepted writes, stalled request cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (rd_acc)                   rd_cnt    <= rd_cnt + 32'd1;
      if (req_acc & req_we)         wr_cnt    <= wr_cnt + 32'd1;
      if (req_valid & ~req_ready_q) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_rd    = rd_cnt;
  assign stat_wr    = wr_cnt;
  assign stat_stall = stall_cnt;
`else
  assign stat_rd    = '0;
  assign stat_wr    = '0;
  assign stat_stall = '0;
`endif

endmodule
